// File: rtl/chacha_qr_unit.sv
// chacha_qr_unit
// Iterative ChaCha quarter-round engine. It accepts four 32-bit state words
// over a valid/ready handshake. It applies the four ARX steps of the quarter
// round over 4/STEPS_PER_CYCLE clocks. It then presents the result over a
// second valid/ready handshake. Input and output never overlap: a new quarter
// round is accepted only after the previous result has been collected.
//
// Parameters:
//   STEPS_PER_CYCLE  ARX steps per clock, 1 or 2
// Ports:
//   clk                        clock, all logic on rising edge
//   rst                        synchronous reset, active-high
//   in_valid / in_ready        input handshake (in_ready high only in IDLE)
//   in_a..in_d                 input state words
//   out_valid / out_ready      output handshake (out_valid high only in DONE)
//   out_a..out_d               registered result, held until the next result
//   busy                       high while computing or holding a result
module chacha_qr_unit #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    input  logic [31:0] in_d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_c,
    output logic [31:0] out_d,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    localparam logic [2:0] STEP_INC = 3'(STEPS_PER_CYCLE);

    state_t      state_reg, state_next;
    logic [2:0]  step_reg, step_next;
    logic [31:0] a_reg, b_reg, c_reg, d_reg;
    logic [31:0] a_next, b_next, c_next, d_next;
    logic [31:0] oa_reg, ob_reg, oc_reg, od_reg;
    logic [31:0] oa_next, ob_next, oc_next, od_next;

    // Combinational chain of ARX steps. Element 0 is the working register set.
    // Element gi+1 is the result of applying step (step_reg + gi).
    logic [31:0] ch_a [0:STEPS_PER_CYCLE];
    logic [31:0] ch_b [0:STEPS_PER_CYCLE];
    logic [31:0] ch_c [0:STEPS_PER_CYCLE];
    logic [31:0] ch_d [0:STEPS_PER_CYCLE];

    assign ch_a[0] = a_reg;
    assign ch_b[0] = b_reg;
    assign ch_c[0] = c_reg;
    assign ch_d[0] = d_reg;

    generate
        for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            logic [1:0]  idx;
            logic [31:0] sa, sb, sc, sd, x;

            // Zero-based step index: even -> a/d half-step, odd -> c/b half-step.
            // idx[1] selects the second pair of rotate amounts (8/7 vs 16/12).
            assign idx = step_reg[1:0] + 2'(gi);

            always_comb begin
                sa = ch_a[gi];
                sb = ch_b[gi];
                sc = ch_c[gi];
                sd = ch_d[gi];
                x  = '0;
                if (!idx[0]) begin
                    sa = ch_a[gi] + ch_b[gi];
                    x  = ch_d[gi] ^ sa;
                    sd = idx[1] ? {x[23:0], x[31:24]} : {x[15:0], x[31:16]};
                end else begin
                    sc = ch_c[gi] + ch_d[gi];
                    x  = ch_b[gi] ^ sc;
                    sb = idx[1] ? {x[24:0], x[31:25]} : {x[19:0], x[31:20]};
                end
            end

            assign ch_a[gi+1] = sa;
            assign ch_b[gi+1] = sb;
            assign ch_c[gi+1] = sc;
            assign ch_d[gi+1] = sd;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        oa_next    = oa_reg;
        ob_next    = ob_reg;
        oc_next    = oc_reg;
        od_next    = od_reg;

        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    a_next     = in_a;
                    b_next     = in_b;
                    c_next     = in_c;
                    d_next     = in_d;
                    step_next  = '0;
                    state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                a_next    = ch_a[STEPS_PER_CYCLE];
                b_next    = ch_b[STEPS_PER_CYCLE];
                c_next    = ch_c[STEPS_PER_CYCLE];
                d_next    = ch_d[STEPS_PER_CYCLE];
                step_next = step_reg + STEP_INC;
                if (step_reg + STEP_INC == 3'd4) begin
                    // Result is latched into the separate output registers so
                    // out_* stay put through the next load and compute.
                    oa_next    = ch_a[STEPS_PER_CYCLE];
                    ob_next    = ch_b[STEPS_PER_CYCLE];
                    oc_next    = ch_c[STEPS_PER_CYCLE];
                    od_next    = ch_d[STEPS_PER_CYCLE];
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            step_reg  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            oa_reg    <= '0;
            ob_reg    <= '0;
            oc_reg    <= '0;
            od_reg    <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            oa_reg    <= oa_next;
            ob_reg    <= ob_next;
            oc_reg    <= oc_next;
            od_reg    <= od_next;
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg != S_IDLE);
    assign out_a     = oa_reg;
    assign out_b     = ob_reg;
    assign out_c     = oc_reg;
    assign out_d     = od_reg;

endmodule

// File: tb/tb_chacha_qr_unit.sv
// Testbench for chacha_qr_unit. Two instances run side by side: index 0 uses
// STEPS_PER_CYCLE=1 and index 1 uses STEPS_PER_CYCLE=2. A reference quarter
// round computes the expected result of every accepted input. A monitor per
// instance compares each presented result, in order, against that reference.
module tb_chacha_qr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_a      [2];
    logic [31:0] in_b      [2];
    logic [31:0] in_c      [2];
    logic [31:0] in_d      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_a     [2];
    logic [31:0] out_b     [2];
    logic [31:0] out_c     [2];
    logic [31:0] out_d     [2];
    logic        busy      [2];

    int n_cmp = 0;
    int n_bad = 0;
    int n_done [2];

    localparam logic [127:0] RFC_IN  = 128'h11111111_01020304_9b8d6f43_01234567;
    localparam logic [127:0] RFC_OUT = 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            chacha_qr_unit #(.STEPS_PER_CYCLE(gi + 1)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid[gi]),
                .in_ready (in_ready[gi]),
                .in_a     (in_a[gi]),
                .in_b     (in_b[gi]),
                .in_c     (in_c[gi]),
                .in_d     (in_d[gi]),
                .out_valid(out_valid[gi]),
                .out_ready(out_ready[gi]),
                .out_a    (out_a[gi]),
                .out_b    (out_b[gi]),
                .out_c    (out_c[gi]),
                .out_d    (out_d[gi]),
                .busy     (busy[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference quarter round: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12;
    // a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
    function automatic logic [127:0] qr_model(input logic [127:0] w);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = w;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] outw(input int k);
        return {out_a[k], out_b[k], out_c[k], out_d[k]};
    endfunction

    // Per-instance scoreboard, sampled on the falling edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mon
            logic [127:0] exp_q [$];
            always @(negedge clk) begin
                if (rst) begin
                    exp_q.delete();
                end else begin
                    chk($sformatf("in_ready_vs_busy[%0d]", gi), 128'(in_ready[gi]), 128'(!busy[gi]));
                    if (out_valid[gi]) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("unexpected_out_valid[%0d]", gi), 128'(out_valid[gi]), 128'd0);
                        end else begin
                            chk($sformatf("result[%0d]", gi), outw(gi), exp_q[0]);
                            if (out_ready[gi]) begin
                                void'(exp_q.pop_front());
                                n_done[gi]++;
                            end
                        end
                    end
                    if (in_valid[gi] && in_ready[gi]) begin
                        exp_q.push_back(qr_model({in_a[gi], in_b[gi], in_c[gi], in_d[gi]}));
                    end
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [127:0] w);
        int t = 0;
        while (!in_ready[k] && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready[k]) chk("send_timeout", 128'(in_ready[k]), 128'd1);
        {in_a[k], in_b[k], in_c[k], in_d[k]} = w;
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int edges);
        edges = 0;
        while (!out_valid[k] && edges < 50) begin
            tick();
            edges++;
        end
        if (!out_valid[k]) chk("out_valid_timeout", 128'(out_valid[k]), 128'd1);
    endtask

    task automatic consume(input int k);
        int e;
        wait_valid(k, e);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic run_random(input int k);
        int base;
        base = n_done[k];
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(k, {$urandom(), $urandom(), $urandom(), $urandom()});
                end
            end
            begin
                int t = 0;
                while (n_done[k] < base + 100 && t < 5000) begin
                    out_ready[k] = 1'($urandom_range(0, 1));
                    tick();
                    t++;
                end
                out_ready[k] = 1'b0;
            end
        join
        chk($sformatf("random_count[%0d]", k), 128'(n_done[k] - base), 128'd100);
    endtask

    initial begin
        logic [127:0] snap;
        int e;

        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            {in_a[k], in_b[k], in_c[k], in_d[k]} = '0;
            n_done[k] = 0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        for (int k = 0; k < 2; k++) begin
            chk("reset_in_ready", 128'(in_ready[k]), 128'd1);
            chk("reset_out_valid", 128'(out_valid[k]), 128'd0);
            chk("reset_busy", 128'(busy[k]), 128'd0);
            chk("reset_out", outw(k), 128'd0);
        end

        // Literal results that pin the reference itself.
        chk("model_rfc", qr_model(RFC_IN), RFC_OUT);
        chk("model_zero", qr_model(128'd0), 128'd0);

        for (int k = 0; k < 2; k++) begin
            // RFC vector and latency.
            send(k, RFC_IN);
            wait_valid(k, e);
            chk($sformatf("latency_edges[%0d]", k), 128'(e), 128'(4 / (k + 1)));
            chk("rfc_out", outw(k), RFC_OUT);
            consume(k);

            // All-zero and all-ones inputs.
            send(k, 128'd0);
            wait_valid(k, e);
            chk("zero_out", outw(k), 128'd0);
            consume(k);
            send(k, {128{1'b1}});
            wait_valid(k, e);
            chk("ones_out", outw(k), qr_model({128{1'b1}}));
            consume(k);

            // Backpressure: result holds for 10 cycles, then one-cycle accept.
            send(k, RFC_IN);
            wait_valid(k, e);
            snap = outw(k);
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("bp_out_valid", 128'(out_valid[k]), 128'd1);
                chk("bp_in_ready", 128'(in_ready[k]), 128'd0);
                chk("bp_stable", outw(k), snap);
            end
            out_ready[k] = 1'b1;
            tick();
            out_ready[k] = 1'b0;
            chk("bp_release_out_valid", 128'(out_valid[k]), 128'd0);
            chk("bp_release_in_ready", 128'(in_ready[k]), 128'd1);
            chk("bp_out_kept", outw(k), RFC_OUT);

            // in_valid with other data during COMPUTE and DONE is ignored,
            // including the cycle where out_ready is taken.
            send(k, RFC_IN);
            {in_a[k], in_b[k], in_c[k], in_d[k]} = 128'hdeadbeef_cafef00d_01234567_89abcdef;
            in_valid[k] = 1'b1;
            wait_valid(k, e);
            tick();
            tick();
            chk("ignore_out", outw(k), RFC_OUT);
            out_ready[k] = 1'b1;
            tick();
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            chk("ignore_out_valid", 128'(out_valid[k]), 128'd0);
            chk("ignore_in_ready", 128'(in_ready[k]), 128'd1);
            tick();
            chk("ignore_not_accepted", 128'(busy[k]), 128'd0);

            // Reset two cycles into COMPUTE aborts the operation.
            send(k, RFC_IN);
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("abort_in_ready", 128'(in_ready[k]), 128'd1);
            chk("abort_out_valid", 128'(out_valid[k]), 128'd0);
            chk("abort_busy", 128'(busy[k]), 128'd0);
            for (int i = 0; i < 8; i++) begin
                tick();
                chk("abort_no_valid", 128'(out_valid[k]), 128'd0);
            end
            send(k, RFC_IN);
            wait_valid(k, e);
            chk("after_abort_out", outw(k), RFC_OUT);
            consume(k);
        end

        for (int k = 0; k < 2; k++) begin
            run_random(k);
        end
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
